puf_ro_array: RTL and testbench



---
 rtl/puf_ro_array.sv | 116 +++++++++++
 tb/tb_puf_ro_array.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/puf_ro_array.sv
// puf_ro_array: NUM_BITS ring-oscillator PUF cells with windowed counting and per-bit majority vote.
// Optional PUF_STABILITY_FLAG_EN adds the per-bit non-unanimous vote flag output.
module puf_ro_array #(
    parameter int NUM_BITS = 8,
    parameter int CNT_W    = 16,
    parameter int WINDOW   = 1024,
    parameter int VOTES    = 3
) (
    input  logic                clk,
    input  logic                computer_reset_n,
    input  logic                start,
    input  logic [NUM_BITS-1:0] challenge,
    input  logic [NUM_BITS-1:0] ro_tick_a,
    input  logic [NUM_BITS-1:0] ro_tick_b,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] response,
    output logic                response_valid
`ifdef PUF_STABILITY_FLAG_EN
    ,
    output logic [NUM_BITS-1:0] unstable
`endif
);
    localparam int WW = $clog2(WINDOW) + 1;
    localparam int TW = $clog2(VOTES + 1);
    localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
    localparam logic [TW-1:0] VOTES_LAST = TW'(VOTES - 1);
    localparam logic [TW-1:0] VOTES_T    = TW'(VOTES);
    localparam logic [TW-1:0] HALF       = TW'(VOTES / 2);

    typedef enum logic [1:0] {IDLE, COUNT, COMPARE, DONE} state_t;

    state_t                         state;
    logic [NUM_BITS-1:0][CNT_W-1:0] cnt_a, cnt_b, cnt_a_nxt, cnt_b_nxt;
    logic [NUM_BITS-1:0][TW-1:0]    tally, tally_nxt;
    logic [NUM_BITS-1:0]            chal, eval, vote, split;
    logic [WW-1:0]                  win;
    logic [TW-1:0]                  round;

    // Counters hold at all-ones; tally_nxt already includes the current round's vote.
    for (genvar i = 0; i < NUM_BITS; i++) begin : g_cell
        assign cnt_a_nxt[i] = cnt_a[i] + CNT_W'(ro_tick_a[i] & ~&cnt_a[i]);
        assign cnt_b_nxt[i] = cnt_b[i] + CNT_W'(ro_tick_b[i] & ~&cnt_b[i]);
        assign eval[i]      = (cnt_a[i] > cnt_b[i]) ^ chal[i];
        assign tally_nxt[i] = tally[i] + TW'(eval[i]);
        assign vote[i]      = tally_nxt[i] > HALF;
        assign split[i]     = (tally_nxt[i] != '0) && (tally_nxt[i] != VOTES_T);
    end

    always_ff @(posedge clk or negedge computer_reset_n) begin
        if (!computer_reset_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            response       <= '0;
            response_valid <= 1'b0;
            chal           <= '0;
            cnt_a          <= '0;
            cnt_b          <= '0;
            tally          <= '0;
            win            <= '0;
            round          <= '0;
`ifdef PUF_STABILITY_FLAG_EN
            unstable       <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    chal           <= challenge;
                    cnt_a          <= '0;
                    cnt_b          <= '0;
                    tally          <= '0;
                    win            <= '0;
                    round          <= '0;
                    response_valid <= 1'b0;
                    busy           <= 1'b1;
                    state          <= COUNT;
                end
                COUNT: begin
                    cnt_a <= cnt_a_nxt;
                    cnt_b <= cnt_b_nxt;
                    win   <= win + 1'b1;
                    if (win == WIN_LAST) state <= COMPARE;
                end
                COMPARE: begin
                    tally <= tally_nxt;
                    round <= round + 1'b1;
                    cnt_a <= '0;
                    cnt_b <= '0;
                    win   <= '0;
                    if (round == VOTES_LAST) begin
                        state          <= DONE;
                        done           <= 1'b1;
                        response       <= vote;
                        response_valid <= 1'b1;
`ifdef PUF_STABILITY_FLAG_EN
                        unstable       <= split;
`endif
                    end else begin
                        state <= COUNT;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef PUF_STABILITY_FLAG_EN
    logic unused_split;
    assign unused_split = ^split;
`endif
endmodule

// File: tb/tb_puf_ro_array.sv
// tb_puf_ro_array: directed checks of latency, compare/swap, voting, saturation, handshake and reset.
module tb_puf_ro_array;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] challenge = '0;
    logic [7:0] ra = '0, rb = '0;
    logic       busy, done, valid, s_busy, s_done, s_valid;
    logic [7:0] resp, s_resp;
`ifdef PUF_STABILITY_FLAG_EN
    logic [7:0] uns, s_uns;
`endif
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    puf_ro_array #(.NUM_BITS(8), .CNT_W(16), .WINDOW(16), .VOTES(3)) dut (
        .clk(clk), .computer_reset_n(rst_n), .start(start), .challenge(challenge),
        .ro_tick_a(ra), .ro_tick_b(rb), .busy(busy), .done(done),
        .response(resp), .response_valid(valid)
`ifdef PUF_STABILITY_FLAG_EN
        , .unstable(uns)
`endif
    );

    puf_ro_array #(.NUM_BITS(8), .CNT_W(3), .WINDOW(16), .VOTES(3)) dut_sat (
        .clk(clk), .computer_reset_n(rst_n), .start(start), .challenge(challenge),
        .ro_tick_a(ra), .ro_tick_b(rb), .busy(s_busy), .done(s_done),
        .response(s_resp), .response_valid(s_valid)
`ifdef PUF_STABILITY_FLAG_EN
        , .unstable(s_uns)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_ticks(input int c, input int mode);
        int r, p;
        r = (c - 1) / 17;
        p = (c - 1) % 17;
        ra = '0;
        rb = '0;
        if (p < 16) begin
            if (mode == 0) begin
                ra[0] = 1'b1;
                rb[0] = (p % 2 == 0);
            end else if (mode == 1) begin
                if (r == 1) rb[3] = 1'b1;
                else ra[3] = 1'b1;
            end else begin
                ra[1] = 1'b1;
                rb[1] = (p < 5);
                ra[2] = 1'b1;
                rb[2] = (p < 7);
            end
        end
    endtask

    task automatic run(input string tag, input logic [7:0] ch, input int mode, input bit poke,
                       input logic [7:0] exp_resp, input logic [7:0] exp_sat, input logic [7:0] exp_uns);
        int got, n;
        logic [7:0] rm, rs, u, us;
        logic bz_done, bz_after, v_done, v_start, sd, sv;
        got = 0; n = 0; rm = '0; rs = '0; u = '0; us = '0;
        bz_done = 0; bz_after = 1; v_done = 0; v_start = 1; sd = 0; sv = 0;
        @(negedge clk);
        challenge = ch;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        challenge = ~ch;
        for (int c = 1; c <= 60; c++) begin
            if (c == 1) v_start = valid;
            if (done) begin
                n++;
                if (got == 0) begin
                    got = c; rm = resp; rs = s_resp; bz_done = busy; v_done = valid;
                    sd = s_done; sv = s_valid;
`ifdef PUF_STABILITY_FLAG_EN
                    u = uns; us = s_uns;
`endif
                end
            end
            if (got != 0 && c == got + 1) bz_after = busy;
            start = poke && (c == 10);
            set_ticks(c, mode);
            @(negedge clk);
        end
        ra = '0;
        rb = '0;
        chk({tag, "_latency"}, got, 52);
        chk({tag, "_ndone"}, n, 1);
        chk({tag, "_resp"}, rm, exp_resp);
        chk({tag, "_valid"}, v_done, 1);
        chk({tag, "_valid_clr"}, v_start, 0);
        chk({tag, "_busy_done"}, bz_done, 1);
        chk({tag, "_busy_after"}, bz_after, 0);
        if (mode == 2) begin
            chk({tag, "_sat_resp"}, rs, exp_sat);
            chk({tag, "_sat_done"}, {sd, sv}, 2'b11);
        end
`ifdef PUF_STABILITY_FLAG_EN
        chk({tag, "_unstable"}, u, exp_uns);
        if (mode == 2) chk({tag, "_sat_unstable"}, us, 8'h00);
`else
        if (exp_uns != exp_uns) chk({tag, "_unused"}, {u, us}, 0);
`endif
    endtask

    initial begin
        int t1, t2, n;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_resp", resp, 0);
        chk("rst_valid", valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run("basic", 8'h00, 0, 0, 8'h01, 8'h00, 8'h00);
        run("swap", 8'h81, 0, 0, 8'h80, 8'h00, 8'h00);
        run("vote", 8'h00, 1, 0, 8'h08, 8'h00, 8'h08);
        run("sat", 8'h00, 2, 1, 8'h06, 8'h02, 8'h00);

        // Held start with no ticks and an all-ones mask: response ends 0xFF.
        t1 = 0; t2 = 0; n = 0;
        @(negedge clk);
        challenge = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 170; c++) begin
            if (done) begin
                n++;
                if (t1 == 0) t1 = c;
                else if (t2 == 0) t2 = c;
            end
            if (c == 100) start = 1'b0;
            @(negedge clk);
        end
        chk("held_ndone", n, 2);
        chk("held_first", t1, 52);
        chk("held_period", t2 - t1, 53);
        chk("held_resp", resp, 8'hFF);

        @(negedge clk);
        challenge = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("midrst_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_resp", resp, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_sat_busy", s_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 60; c++) begin
            if (done) n++;
            @(negedge clk);
        end
        chk("midrst_nodone", n, 0);
        chk("midrst_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
